// File: rtl/count_dn16.sv
// Loadable down-counter/timer with a one-cycle terminal-count pulse.
// Optional autoreload at terminal count: define COUNT_DN16_AUTORELOAD_EN.
module count_dn16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             en,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             zero_q, zero_d;
  logic             tc_q, tc_d;
  logic             load_acc;
  logic             at_term;

`ifdef COUNT_DN16_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  assign load_acc = load_valid & load_ready;
  assign at_term  = (state_q == RUN) & en
                  & (count_q == WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else if (load_acc) begin
      state_d = (load_data != '0) ? RUN : IDLE;
    end else if (at_term) begin
`ifdef COUNT_DN16_AUTORELOAD_EN
      state_d = RUN;
`else
      state_d = DONE;
`endif
    end
  end

  always_comb begin
    busy       = (state_q == RUN);
    load_ready = (state_q != RUN);
    count      = count_q;
    zero       = zero_q;
    tc         = tc_q;
  end

  // Datapath; stop overrides any load or decrement and freezes count.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
`ifdef COUNT_DN16_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (!stop) begin
      if (load_acc) begin
        count_d = load_data;
`ifdef COUNT_DN16_AUTORELOAD_EN
        if (load_data != '0) reload_d = load_data;
`endif
      end else if (at_term) begin
        tc_d = 1'b1;
`ifdef COUNT_DN16_AUTORELOAD_EN
        count_d = reload_q;
`else
        count_d = '0;
`endif
      end else if (state_q == RUN && en) begin
        count_d = count_q - WIDTH'(1);
      end
    end
    zero_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      zero_q  <= 1'b1;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      zero_q  <= zero_d;
      tc_q    <= tc_d;
    end
  end

`ifdef COUNT_DN16_AUTORELOAD_EN
  always_ff @(posedge clk) begin
    if (rst) reload_q <= '0;
    else     reload_q <= reload_d;
  end
`endif

endmodule

// File: tb/tb_count_dn16.sv
// Bench for count_dn16: behavioural model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_count_dn16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic        en = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] count;
  logic        busy, zero, tc;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  count_dn16 #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .en(en), .stop(stop),
    .count(count), .busy(busy), .zero(zero), .tc(tc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int cnt;
    bit run;
    bit tcp;
    int rel;
  } mdl_t;

  mdl_t m = '{cnt: 0, run: 1'b0, tcp: 1'b0, rel: 0};

  // Model: remaining count as an integer; a run ends when it reaches 0.
  function automatic mdl_t next_m(mdl_t c, bit r, bit s,
                                  bit lv, int ld, bit e);
    mdl_t n = c;
    n.tcp = 1'b0;
    if (r) begin
      n.cnt = 0; n.run = 1'b0; n.rel = 0;
    end else if (s) begin
      n.run = 1'b0;
    end else if (!c.run && lv) begin
      n.cnt = ld;
      n.run = (ld != 0);
      if (ld != 0) n.rel = ld;
    end else if (c.run && e) begin
      n.cnt = c.cnt - 1;
      if (n.cnt == 0) begin
        n.tcp = 1'b1;
`ifdef COUNT_DN16_AUTORELOAD_EN
        n.cnt = c.rel;
`else
        n.run = 1'b0;
`endif
      end
    end
    return n;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(posedge clk)
    m <= next_m(m, rst, stop, load_valid, int'(load_data), en);

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_count", int'(count), m.cnt);
      chk("m_zero", int'(zero), int'(m.cnt == 0));
      chk("m_busy", int'(busy), int'(m.run));
      chk("m_ready", int'(load_ready), int'(!m.run));
      chk("m_tc", int'(tc), int'(m.tcp));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_stop();
    load_valid = 1'b0; en = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic do_load(int v);
    load_valid = 1'b1; load_data = 16'(v);
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    int exp_c [4];
    int exp_b [4];
    int lat;
    int t;

    tick(); tick();
    chk_on = 1'b1;
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_count", int'(count), 0);
      chk("idle_zero", int'(zero), 1);
      chk("idle_ready", int'(load_ready), 1);
      chk("idle_busy", int'(busy), 0);
      chk("idle_tc", int'(tc), 0);
    end

    // Load 3, en high
`ifdef COUNT_DN16_AUTORELOAD_EN
    exp_c = '{3, 2, 1, 3};
    exp_b = '{1, 1, 1, 1};
`else
    exp_c = '{3, 2, 1, 0};
    exp_b = '{1, 1, 1, 0};
`endif
    en = 1'b1;
    do_load(3);
    for (int i = 0; i < 4; i++) begin
      chk("ld3_count", int'(count), exp_c[i]);
      chk("ld3_busy", int'(busy), exp_b[i]);
      chk("ld3_tc", int'(tc), int'(i == 3));
      if (i < 3) tick();
    end
    tick();
    chk("ld3_tc_off", int'(tc), 0);
    do_stop();

    // Load 5, en toggling from the edge after the load
    do_load(5);
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      en = (k % 2 == 1);
      tick();
      if (tc) lat = k;
    end
    chk("toggle_latency", lat, 9);
    do_stop();

    // Load 0
    en = 1'b1;
    do_load(0);
    chk("ld0_busy", int'(busy), 0);
    chk("ld0_tc", int'(tc), 0);
    chk("ld0_ready", int'(load_ready), 1);
    chk("ld0_zero", int'(zero), 1);
    tick();
    chk("ld0_busy2", int'(busy), 0);

    // Load 0xFFFF, en high
    do_load(16'hFFFF);
    lat = -1;
    t = 0;
    while (lat < 0 && t < 70000) begin
      tick();
      t++;
      if (tc) lat = t;
    end
    chk("ffff_latency", lat, 65535);
    do_stop();

    // Load 10, stop at count 6
    en = 1'b1;
    do_load(10);
    for (int i = 0; i < 4; i++) tick();
    do_stop();
    chk("stop_count", int'(count), 6);
    chk("stop_busy", int'(busy), 0);
    chk("stop_tc", int'(tc), 0);
    chk("stop_ready", int'(load_ready), 1);

    // Reset one edge before terminal count
    en = 1'b1;
    do_load(2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_count", int'(count), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_tc", int'(tc), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(load_ready), 1);

`ifdef COUNT_DN16_AUTORELOAD_EN
    // Autoreload of 2
    en = 1'b1;
    do_load(2);
    for (int i = 0; i < 6; i++) begin
      chk("ar_count", int'(count), (i % 2 == 0) ? 2 : 1);
      chk("ar_tc", int'(tc), int'(i > 0 && i % 2 == 0));
      chk("ar_busy", int'(busy), 1);
      tick();
    end
    do_stop();
`endif

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      stop       = ($urandom_range(0, 19) == 0);
      load_valid = ($urandom_range(0, 3) == 0);
      en         = ($urandom_range(0, 3) != 0);
      load_data  = ($urandom_range(0, 7) == 0) ?
                   16'($urandom_range(0, 65535)) :
                   16'($urandom_range(0, 12));
      tick();
    end
    rst = 1'b0; stop = 1'b0; load_valid = 1'b0; en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
